riscv_ex_seq: RTL and testbench

Execute-stage sequencer between ID and MEM. It accepts one decoded operation per handshake and configures the shared ALU (op select, operand-B mux). It also runs M-extension ops on an internal iterative multiply/divide engine, stalling ID with ready/valid until the result is registered for MEM.

---
 rtl/riscv_ex_pkg.sv | 74 +++++++
 rtl/riscv_ex_mdu_iter.sv | 136 +++++++++++++
 rtl/riscv_ex_seq.sv | 144 ++++++++++++++
 tb/tb_riscv_ex_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ex_pkg.sv
// Shared types for the execute-stage sequencer: EX/ALU opcodes, FSM states and op helpers.
package riscv_ex_pkg;

   localparam int unsigned EX_OP_W  = 5;
   localparam int unsigned ALU_OP_W = 4;

   typedef enum logic [EX_OP_W-1:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_MUL    = 5'd10,
      OP_MULH   = 5'd11,
      OP_MULHSU = 5'd12,
      OP_MULHU  = 5'd13,
      OP_DIV    = 5'd14,
      OP_DIVU   = 5'd15,
      OP_REM    = 5'd16,
      OP_REMU   = 5'd17
   } ex_op_e;

   typedef enum logic [ALU_OP_W-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_DIVI = 2'd2,
      S_DONE = 2'd3
   } ex_state_e;

   function automatic logic is_mdu_op(input ex_op_e op);
      return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                        OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic logic is_div_op(input ex_op_e op);
      return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   endfunction

   function automatic alu_op_e to_alu_op(input ex_op_e op);
      alu_op_e r;
      case (op)
         OP_SUB:  r = ALU_SUB;
         OP_AND:  r = ALU_AND;
         OP_OR:   r = ALU_OR;
         OP_XOR:  r = ALU_XOR;
         OP_SLL:  r = ALU_SLL;
         OP_SRL:  r = ALU_SRL;
         OP_SRA:  r = ALU_SRA;
         OP_SLT:  r = ALU_SLT;
         OP_SLTU: r = ALU_SLTU;
         default: r = ALU_ADD;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/riscv_ex_mdu_iter.sv
// Iterative radix-2 multiply / restoring divide engine with sign fixup and fast-path detection.
// RISCV_EX_FAST_MUL_EN turns every multiply into a single-cycle fast-path result.
module riscv_ex_mdu_iter
   import riscv_ex_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned CNT_W     = $clog2(WORD_SIZE)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [4:0]           op_i,
   input  logic [WORD_SIZE-1:0] a_i,
   input  logic [WORD_SIZE-1:0] b_i,
   output logic                 quick_c,
   output logic [WORD_SIZE-1:0] quick_res_c,
   output logic                 done_c,
   output logic [WORD_SIZE-1:0] res_c
);

   localparam int unsigned W = WORD_SIZE;

   ex_op_e         op;
   logic           is_div, sel_hi, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
   logic [W-1:0]   a_mag, b_mag;
   logic [W:0]     mul_sum, div_sh, div_diff;
   logic           div_ge, last;
   logic [2*W-1:0] step, fin_prod;
   logic [W-1:0]   fin_q, fin_r;
`ifdef RISCV_EX_FAST_MUL_EN
   logic [2*W-1:0] fast_prod;
`endif

   logic           run_q, run_d, div_q, div_d, hi_q, hi_d, negq_q, negq_d, negr_q, negr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2*W-1:0] p_q, p_d;
   logic [W-1:0]   m_q, m_d;

   // Operand decode, magnitudes and the cases that bypass iteration
   always_comb begin
      op       = ex_op_e'(op_i);
      is_div   = is_div_op(op);
      sel_hi   = op inside {OP_MULH, OP_MULHSU, OP_MULHU, OP_REM, OP_REMU};
      a_sgn    = op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
      b_sgn    = op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
      a_neg    = a_sgn & a_i[W-1];
      b_neg    = b_sgn & b_i[W-1];
      a_mag    = a_neg ? (~a_i + W'(1)) : a_i;
      b_mag    = b_neg ? (~b_i + W'(1)) : b_i;
      div_zero = is_div & (b_i == '0);
      div_ovf  = is_div & a_sgn & (a_i == {1'b1, {(W-1){1'b0}}}) & (&b_i);
      quick_c     = div_zero | div_ovf;
      quick_res_c = '0;
      if (div_zero) begin
         quick_res_c = sel_hi ? a_i : '1;
      end else if (div_ovf) begin
         quick_res_c = sel_hi ? '0 : {1'b1, {(W-1){1'b0}}};
      end
`ifdef RISCV_EX_FAST_MUL_EN
      fast_prod = {{W{a_neg}}, a_i} * {{W{b_neg}}, b_i};
      if (!is_div) begin
         quick_c     = 1'b1;
         quick_res_c = sel_hi ? fast_prod[2*W-1:W] : fast_prod[W-1:0];
      end
`endif
   end

   // One iteration step: p holds {acc, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum  = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, m_q} : (W+1)'(0));
      div_sh   = {p_q[2*W-1:W], p_q[W-1]};
      div_diff = div_sh - {1'b0, m_q};
      div_ge   = div_sh >= {1'b0, m_q};
      step     = div_q ? {(div_ge ? div_diff[W-1:0] : div_sh[W-1:0]), p_q[W-2:0], div_ge}
                       : {mul_sum, p_q[W-1:1]};
      last     = run_q & (cnt_q == CNT_W'(W - 1));
      fin_prod = negq_q ? (~step + (2*W)'(1)) : step;
      fin_q    = negq_q ? (~step[W-1:0] + W'(1)) : step[W-1:0];
      fin_r    = negr_q ? (~step[2*W-1:W] + W'(1)) : step[2*W-1:W];
      res_c    = div_q ? (hi_q ? fin_r : fin_q)
                       : (hi_q ? fin_prod[2*W-1:W] : fin_prod[W-1:0]);
      done_c   = last;
   end

   always_comb begin
      run_d  = run_q;
      cnt_d  = cnt_q;
      p_d    = p_q;
      m_d    = m_q;
      div_d  = div_q;
      hi_d   = hi_q;
      negq_d = negq_q;
      negr_d = negr_q;
      if (abort_i) begin
         run_d = 1'b0;
         cnt_d = '0;
      end else if (start_i) begin
         run_d  = 1'b1;
         cnt_d  = '0;
         p_d    = {{W{1'b0}}, (is_div ? a_mag : b_mag)};
         m_d    = is_div ? b_mag : a_mag;
         div_d  = is_div;
         hi_d   = sel_hi;
         negq_d = a_neg ^ b_neg;
         negr_d = a_neg;
      end else if (run_q) begin
         p_d   = step;
         cnt_d = last ? '0 : cnt_q + CNT_W'(1);
         run_d = ~last;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q  <= 1'b0;
         cnt_q  <= '0;
         p_q    <= '0;
         m_q    <= '0;
         div_q  <= 1'b0;
         hi_q   <= 1'b0;
         negq_q <= 1'b0;
         negr_q <= 1'b0;
      end else begin
         run_q  <= run_d;
         cnt_q  <= cnt_d;
         p_q    <= p_d;
         m_q    <= m_d;
         div_q  <= div_d;
         hi_q   <= hi_d;
         negq_q <= negq_d;
         negr_q <= negr_d;
      end
   end

endmodule

// File: rtl/riscv_ex_seq.sv
// Execute-stage sequencer: drives the shared ALU and runs M-extension ops on the iterative engine.
// RISCV_EX_FAST_MUL_EN: multiplies complete at accept and the MULT state is not used.
module riscv_ex_seq
   import riscv_ex_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned CNT_W     = $clog2(WORD_SIZE)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [4:0]           op_i,
   input  logic                 src_imm_i,
   input  logic [WORD_SIZE-1:0] rs1_i,
   input  logic [WORD_SIZE-1:0] rs2_i,
   input  logic [WORD_SIZE-1:0] imm_i,
   output logic [3:0]           alu_op_o,
   output logic [WORD_SIZE-1:0] alu_a_o,
   output logic [WORD_SIZE-1:0] alu_b_o,
   input  logic [WORD_SIZE-1:0] alu_result_i,
   input  logic                 alu_zero_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [WORD_SIZE-1:0] result_o,
   output logic                 zero_o,
   output logic                 busy_o
);

   ex_state_e            state_q, state_d;
   logic                 out_valid_q, out_valid_d, zero_q, zero_d, busy_q, busy_d;
   logic [WORD_SIZE-1:0] result_q, result_d;

   ex_op_e               op;
   logic                 mdu_op, accept, mdu_start, mdu_quick, mdu_done;
   logic [WORD_SIZE-1:0] mdu_quick_res, mdu_res;

   riscv_ex_mdu_iter #(
      .WORD_SIZE (WORD_SIZE),
      .CNT_W     (CNT_W)
   ) u_mdu (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .start_i     (mdu_start),
      .abort_i     (flush_i),
      .op_i        (op_i),
      .a_i         (rs1_i),
      .b_i         (rs2_i),
      .quick_c     (mdu_quick),
      .quick_res_c (mdu_quick_res),
      .done_c      (mdu_done),
      .res_c       (mdu_res)
   );

   // Handshake and the combinational ALU drive for the op being accepted
   always_comb begin
      op         = ex_op_e'(op_i);
      mdu_op     = is_mdu_op(op);
      in_ready_o = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready_i);
      accept     = in_valid_i & in_ready_o & ~flush_i;
      alu_op_o   = (accept & ~mdu_op) ? to_alu_op(op) : ALU_ADD;
      alu_a_o    = rs1_i;
      alu_b_o    = src_imm_i ? imm_i : rs2_i;
   end

   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      mdu_start   = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if ((state_q == S_DONE) && out_ready_i) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
            end
            if (accept) begin
               if (!mdu_op) begin
                  result_d    = alu_result_i;
                  zero_d      = alu_zero_i;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else if (mdu_quick) begin
                  result_d    = mdu_quick_res;
                  zero_d      = (mdu_quick_res == '0);
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else begin
                  mdu_start   = 1'b1;
                  out_valid_d = 1'b0;
`ifdef RISCV_EX_FAST_MUL_EN
                  state_d     = S_DIVI;
`else
                  state_d     = is_div_op(op) ? S_DIVI : S_MULT;
`endif
               end
            end
         end
`ifdef RISCV_EX_FAST_MUL_EN
         S_DIVI: begin
`else
         S_MULT, S_DIVI: begin
`endif
            if (mdu_done) begin
               result_d    = mdu_res;
               zero_d      = (mdu_res == '0);
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush kills whatever is in flight, including a result waiting for MEM
      if (flush_i) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end
      busy_d = (state_d == S_MULT) | (state_d == S_DIVI);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         busy_q      <= busy_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign result_o    = result_q;
   assign zero_o      = zero_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_riscv_ex_seq.sv
// Self-checking bench for riscv_ex_seq: vector table, multi-cycle corner sequences, random ops vs model.
module tb_riscv_ex_seq;
   import riscv_ex_pkg::*;

`ifdef RISCV_EX_FAST_MUL_EN
   localparam int ML = 1;
`else
   localparam int ML = 33;
`endif
   localparam int DL = 33;

   logic        clk = 1'b0;
   logic        rst_i, flush_i, in_valid_i, in_ready_o, src_imm_i;
   logic [4:0]  op_i;
   logic [31:0] rs1_i, rs2_i, imm_i, alu_a_o, alu_b_o, alu_result_i, result_o;
   logic [3:0]  alu_op_o;
   logic        alu_zero_i, out_valid_o, out_ready_i, zero_o, busy_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   riscv_ex_seq dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .op_i         (op_i),
      .src_imm_i    (src_imm_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .imm_i        (imm_i),
      .alu_op_o     (alu_op_o),
      .alu_a_o      (alu_a_o),
      .alu_b_o      (alu_b_o),
      .alu_result_i (alu_result_i),
      .alu_zero_i   (alu_zero_i),
      .out_valid_o  (out_valid_o),
      .out_ready_i  (out_ready_i),
      .result_o     (result_o),
      .zero_o       (zero_o),
      .busy_o       (busy_o)
   );

   // Behavioural model of the shared ALU
   always_comb begin
      case (alu_op_e'(alu_op_o))
         ALU_ADD:  alu_result_i = alu_a_o + alu_b_o;
         ALU_SUB:  alu_result_i = alu_a_o - alu_b_o;
         ALU_AND:  alu_result_i = alu_a_o & alu_b_o;
         ALU_OR:   alu_result_i = alu_a_o | alu_b_o;
         ALU_XOR:  alu_result_i = alu_a_o ^ alu_b_o;
         ALU_SLL:  alu_result_i = alu_a_o << alu_b_o[4:0];
         ALU_SRL:  alu_result_i = alu_a_o >> alu_b_o[4:0];
         ALU_SRA:  alu_result_i = 32'($signed(alu_a_o) >>> alu_b_o[4:0]);
         ALU_SLT:  alu_result_i = {31'b0, $signed(alu_a_o) < $signed(alu_b_o)};
         ALU_SLTU: alu_result_i = {31'b0, alu_a_o < alu_b_o};
         default:  alu_result_i = 32'h0;
      endcase
   end
   assign alu_zero_i = (alu_result_i == 32'h0);

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [3:0] exp_alu_op(input logic [4:0] op);
      case (op)
         OP_SUB:  return ALU_SUB;
         OP_AND:  return ALU_AND;
         OP_OR:   return ALU_OR;
         OP_XOR:  return ALU_XOR;
         OP_SLL:  return ALU_SLL;
         OP_SRL:  return ALU_SRL;
         OP_SRA:  return ALU_SRA;
         OP_SLT:  return ALU_SLT;
         OP_SLTU: return ALU_SLTU;
         default: return ALU_ADD;
      endcase
   endfunction

   // Reference result from RISC-V arithmetic rules in 64-bit integer math
   function automatic logic [31:0] ref_calc(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p;
      longint unsigned ua, ub, up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      case (op)
         OP_ADD:    return a + b;
         OP_SUB:    return a - b;
         OP_AND:    return a & b;
         OP_OR:     return a | b;
         OP_XOR:    return a ^ b;
         OP_SLL:    return a << b[4:0];
         OP_SRL:    return a >> b[4:0];
         OP_SRA:    return 32'($signed(a) >>> b[4:0]);
         OP_SLT:    return (sa < sb) ? 32'd1 : 32'd0;
         OP_SLTU:   return (ua < ub) ? 32'd1 : 32'd0;
         OP_MUL:    begin p = sa * sb; return p[31:0]; end
         OP_MULH:   begin p = sa * sb; return p[63:32]; end
         OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
         OP_MULHU:  begin up = ua * ub; return up[63:32]; end
         OP_DIV: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            p = sa / sb; return p[31:0];
         end
         OP_DIVU: begin
            if (b == 32'h0) return 32'hFFFF_FFFF;
            up = ua / ub; return up[31:0];
         end
         OP_REM: begin
            if (b == 32'h0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         OP_REMU: begin
            if (b == 32'h0) return a;
            up = ua % ub; return up[31:0];
         end
         default:   return 32'h0;
      endcase
   endfunction

   function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op < 5'(OP_MUL)) return 1;
      if (op < 5'(OP_DIV)) return ML;
      if (b == 32'h0) return 1;
      if ((op == 5'(OP_DIV) || op == 5'(OP_REM)) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return DL;
   endfunction

   function automatic logic [31:0] rnd_word();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 10));
         default: return $urandom;
      endcase
   endfunction

   task automatic wait_ready(input string nm);
      int guard = 0;
      while (!in_ready_o && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready_o) check({nm, "_ready_timeout"}, 64'(in_ready_o), 64'd1);
   endtask

   // Issue one op, then measure latency, busy cycles and the registered result
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b2,
                        input logic [31:0] im, input logic si, input logic [31:0] er,
                        input int el, input string nm);
      int lat, busy_n;
      @(negedge clk);
      wait_ready(nm);
      in_valid_i = 1'b1; op_i = op; rs1_i = a; rs2_i = b2; imm_i = im; src_imm_i = si;
      #1;
      if (op < 5'(OP_MUL)) begin
         check({nm, "_alu_op"}, 64'(alu_op_o), 64'(exp_alu_op(op)));
         check({nm, "_alu_b"}, 64'(alu_b_o), 64'(si ? im : b2));
      end
      @(negedge clk);
      in_valid_i = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!out_valid_o && lat < 100) begin
         if (busy_o) busy_n++;
         @(negedge clk);
         lat++;
      end
      check({nm, "_lat"}, 64'(lat), 64'(el));
      check({nm, "_res"}, 64'(result_o), 64'(er));
      check({nm, "_zero"}, 64'(zero_o), 64'(er == 32'h0));
      if (el > 1) check({nm, "_busy_cycles"}, 64'(busy_n), 64'(el - 1));
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, imm;
      logic        si;
      logic [31:0] res;
      int          lat;
      string       nm;
   } vec_t;

   vec_t vecs[16];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      logic [4:0]  rop;
      logic [31:0] ra, rb, rimm, beff, rexp;
      logic        rsi;

      rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
      op_i = 5'd0; src_imm_i = 1'b0; rs1_i = 32'h0; rs2_i = 32'h0; imm_i = 32'h0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid_o), 64'd0);
      check("rst_result", 64'(result_o), 64'd0);
      check("rst_zero", 64'(zero_o), 64'd0);
      check("rst_busy", 64'(busy_o), 64'd0);
      check("rst_alu_op", 64'(alu_op_o), 64'(ALU_ADD));
      check("rst_in_ready", 64'(in_ready_o), 64'd1);
      rst_i = 1'b0;

      vecs[0]  = '{OP_ADD,    32'd5,         32'd0,         32'd7, 1'b1, 32'd12,        1,  "add_imm"};
      vecs[1]  = '{OP_SUB,    32'd9,         32'd9,         32'd3, 1'b0, 32'd0,         1,  "sub_zero"};
      vecs[2]  = '{OP_SLT,    32'hFFFF_FFFF, 32'd1,         32'd0, 1'b0, 32'd1,         1,  "slt_neg"};
      vecs[3]  = '{OP_SRA,    32'h8000_0000, 32'd0,         32'd4, 1'b1, 32'hF800_0000, 1,  "sra_imm"};
      vecs[4]  = '{OP_MUL,    32'hFFFF_FFFD, 32'd7,         32'd0, 1'b0, 32'hFFFF_FFEB, ML, "mul_neg"};
      vecs[5]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFE, ML, "mulhu_max"};
      vecs[6]  = '{OP_MULH,   32'hFFFF_FFFD, 32'd7,         32'd0, 1'b0, 32'hFFFF_FFFF, ML, "mulh_neg"};
      vecs[7]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'hFFFF_FFFF, ML, "mulhsu"};
      vecs[8]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 32'hFFFF_FFFD, DL, "div_neg"};
      vecs[9]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'd0, 1'b0, 32'hFFFF_FFFF, DL, "rem_neg"};
      vecs[10] = '{OP_DIVU,   32'd100,       32'd0,         32'd0, 1'b0, 32'hFFFF_FFFF, 1,  "divu_by0"};
      vecs[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'd0,         1,  "rem_ovf"};
      vecs[12] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0, 32'h8000_0000, 1,  "div_ovf"};
      vecs[13] = '{OP_REMU,   32'd100,       32'd0,         32'd0, 1'b0, 32'd100,       1,  "remu_by0"};
      vecs[14] = '{OP_MUL,    32'd7,         32'd6,         32'd0, 1'b1, 32'd42,        ML, "mul_ignimm"};
      vecs[15] = '{OP_DIVU,   32'hFFFF_FFFF, 32'd3,         32'd0, 1'b0, 32'h5555_5555, DL, "divu_big"};

      foreach (vecs[i])
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].si,
               vecs[i].res, vecs[i].lat, vecs[i].nm);

      // Back-to-back ALU ops: one result per cycle
      @(negedge clk);
      wait_ready("b2b");
      in_valid_i = 1'b1; src_imm_i = 1'b0; op_i = OP_ADD; rs1_i = 32'd1; rs2_i = 32'd2;
      @(negedge clk);
      check("b2b_v1", 64'(out_valid_o), 64'd1);
      check("b2b_r1", 64'(result_o), 64'd3);
      op_i = OP_SUB; rs1_i = 32'd10; rs2_i = 32'd4;
      @(negedge clk);
      check("b2b_v2", 64'(out_valid_o), 64'd1);
      check("b2b_r2", 64'(result_o), 64'd6);
      op_i = OP_XOR; rs1_i = 32'hF0; rs2_i = 32'hFF;
      @(negedge clk);
      check("b2b_v3", 64'(out_valid_o), 64'd1);
      check("b2b_r3", 64'(result_o), 64'h0F);
      in_valid_i = 1'b0;
      @(negedge clk);
      check("b2b_drain", 64'(out_valid_o), 64'd0);

      // Backpressure from MEM holds the result and blocks new ops
      out_ready_i = 1'b0;
      wait_ready("bp");
      in_valid_i = 1'b1; op_i = OP_ADD; rs1_i = 32'd1; rs2_i = 32'd2;
      @(negedge clk);
      rs1_i = 32'd10; rs2_i = 32'd20;
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 64'(out_valid_o), 64'd1);
         check("bp_hold", 64'(result_o), 64'd3);
         check("bp_not_ready", 64'(in_ready_o), 64'd0);
         @(negedge clk);
      end
      out_ready_i = 1'b1;
      #1;
      check("bp_release_ready", 64'(in_ready_o), 64'd1);
      @(negedge clk);
      in_valid_i = 1'b0;
      check("bp_new_valid", 64'(out_valid_o), 64'd1);
      check("bp_new_res", 64'(result_o), 64'd30);

      // Random ops against the reference model
      for (int i = 0; i < 150; i++) begin
         rop  = 5'($urandom_range(0, 17));
         ra   = rnd_word();
         rb   = rnd_word();
         rimm = rnd_word();
         rsi  = 1'($urandom_range(0, 1));
         beff = (rop < 5'(OP_MUL) && rsi) ? rimm : rb;
         rexp = ref_calc(rop, ra, beff);
         do_op(rop, ra, rb, rimm, rsi, rexp, exp_lat(rop, ra, beff), "rand");
      end

      // Flush at cycle 10 of a divide, with a new op offered in the same cycle
      @(negedge clk);
      wait_ready("flush");
      in_valid_i = 1'b1; op_i = OP_DIVU; rs1_i = 32'd1000; rs2_i = 32'd3; src_imm_i = 1'b0;
      @(negedge clk);
      in_valid_i = 1'b0;
      repeat (9) @(negedge clk);
      check("flush_busy_before", 64'(busy_o), 64'd1);
      flush_i = 1'b1; in_valid_i = 1'b1; op_i = OP_ADD; rs1_i = 32'd1; rs2_i = 32'd1;
      @(negedge clk);
      flush_i = 1'b0; in_valid_i = 1'b0;
      check("flush_busy_after", 64'(busy_o), 64'd0);
      check("flush_no_valid", 64'(out_valid_o), 64'd0);
      check("flush_idle_ready", 64'(in_ready_o), 64'd1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid_o) cnt++;
      end
      check("flush_no_late_out", 64'(cnt), 64'd0);
      flush_i = 1'b1; in_valid_i = 1'b1; op_i = OP_ADD; rs1_i = 32'd4; rs2_i = 32'd4;
      @(negedge clk);
      flush_i = 1'b0; in_valid_i = 1'b0;
      check("flush_idle_reject", 64'(out_valid_o), 64'd0);
      do_op(OP_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, 32'd333, DL, "after_flush");

      // Reset in the middle of a multi-cycle op
      @(negedge clk);
      wait_ready("rstmid");
      in_valid_i = 1'b1; rs1_i = 32'd6; rs2_i = 32'd7;
`ifdef RISCV_EX_FAST_MUL_EN
      op_i = OP_DIVU;
`else
      op_i = OP_MUL;
`endif
      @(negedge clk);
      in_valid_i = 1'b0;
      repeat (4) @(negedge clk);
      check("rstmid_busy_before", 64'(busy_o), 64'd1);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      check("rstmid_valid", 64'(out_valid_o), 64'd0);
      check("rstmid_result", 64'(result_o), 64'd0);
      check("rstmid_zero", 64'(zero_o), 64'd0);
      check("rstmid_busy", 64'(busy_o), 64'd0);
      check("rstmid_alu_op", 64'(alu_op_o), 64'(ALU_ADD));
      check("rstmid_ready", 64'(in_ready_o), 64'd1);
      cnt = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid_o) cnt++;
      end
      check("rstmid_no_out", 64'(cnt), 64'd0);
      do_op(OP_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 32'd42, ML, "mul_after_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
